matrix_engine: RTL and testbench
================================

// Module: matrix_engine
// PURPOSE
//  Parametrised memory-mapped matrix coprocessor, successor to the fixed-width 32-bit multiplier FSM.
//  Reads a 4-word dimension header plus operands from shared memory through the single-port
//  mem_operation/mem_opdone interface and writes C back. Adds relocatable base, selectable modes
//  (MUL, ADD, TRANSPOSE, MAC), dimension checking and saturating writeback.
// PARAMETERS
//  DATA_W    32  element/data bus width (header words also DATA_W, zero-extended to ADDR_W)
//  ADDR_W    32  word address width
//  ACC_W     64  accumulator width, must be >= 2*DATA_W
//  SATURATE  1   1: clamp writeback to 2^DATA_W-1; 0: write low DATA_W bits of acc
// PORTS
//  clk            in   1       clock
//  reset          in   1       synchronous, active-high reset
//  enable         in   1       level; rising edge seen in IDLE starts a job, low after DONE/ERR rearms
//  op_mode        in   2       00 MUL C=A*B, 01 ADD C=A+B, 10 TRANSPOSE C=A^T, 11 MAC C=C+A*B; latched at start
//  base_i         in   ADDR_W  header base address; latched at start
//  mem_opdone     in   1       one-cycle pulse: current read data valid / write accepted
//  data_i         in   DATA_W  read data, valid in mem_opdone cycle
//  data_o         out  DATA_W  write data, held stable while mem_operation==11
//  addr_o         out  ADDR_W  word address, held stable while mem_operation!=00
//  mem_operation  out  2       00 none, 01 read, 11 write
//  busy           out  1       high from start until DONE/ERR entered
//  done           out  1       high in DONE until enable low
//  error          out  1       high in ERR until enable low
// BEHAVIOUR
//  Reset (any state, mid-transaction too): state=IDLE, all outputs 0, acc=0, dims=0; an in-flight
//   memory op is abandoned; a mem_opdone arriving afterwards is ignored.
//  Memory map: header at base: +0 width_a, +1 height_a, +2 width_b, +3 height_b.
//   A=base+4 (row-major ha x wa), B=A+ha*wa, C=B+hb*wb (TRANSPOSE: C=B, B not read). Addresses wrap mod 2^ADDR_W.
//  Handshake: block drives addr/op (and data for writes) and holds them until the mem_opdone cycle;
//   next cycle mem_operation=00 for >=1 cycle before the next transaction. mem_opdone while op==00 ignored.
//  FSM: IDLE -> HDR (4 reads, +0..+3) -> CHECK -> ROW/COL/INNER loop -> DONE | ERR.
//   CHECK (1 cycle): ERR if any used dim==0, or MUL/MAC wa!=hb, or ADD (wa!=wb or ha!=hb). No data op in ERR.
//   MUL: per C[i][j]: acc=0; for k<wa: RD_A A[i][k], RD_B B[k][j], MAC acc+=a*b (1 cycle); then WR.
//   MAC: as MUL but acc initialised by RD_C C[i][j] before the k loop.
//   ADD: RD_A A[i][j], RD_B B[i][j], acc=a+b, WR C[i][j]. C dims ha x wa.
//   TRANSPOSE: RD_A A[i][j], WR C[j][i] (C row length = ha).
//   Loop order: i outer (rows of C source), j inner, k innermost; writes in row-major order of i,j.
//  Arithmetic: unsigned; products 2*DATA_W, acc wraps mod 2^ACC_W.
//   Writeback: SATURATE=1 and acc>2^DATA_W-1 -> write all-ones; else acc[DATA_W-1:0].
//  DONE/ERR: busy=0; done/error held while enable=1; enable=0 -> IDLE (flags cleared next cycle).
//   enable held high through IDLE does not restart; needs a low->high transition.
//  op_mode/base_i changes during a job have no effect.
// TESTING
//  MUL base=0x100, hdr {2,2,2,2}, A=[1,2,3,4], B=[5,6,7,8] -> writes 0x10C..0x10F = 19,22,43,50; done=1.
//  ADD same data -> C at 0x10C..0x10F = 6,8,10,12; exactly 12 reads, 4 writes.
//  TRANSPOSE hdr {3,2,x,x}, A=[1,2,3,4,5,6] at 0x104 -> C at 0x10A.. = 1,4,2,5,3,6.
//  MUL hdr {3,2,2,2} (wa!=hb) -> error=1 after 4 header reads, no further mem ops; enable low clears.
//  DATA_W=8, SATURATE=1, 1x1 MUL 16*16 -> writes 255; SATURATE=0 -> writes 0.
//  MAC with C preset=100, 1x1 A=3,B=4 -> writes 112; random mem_opdone delays 0-7 cycles give same results;
//   reset asserted mid-RD_B -> all outputs 0 next cycle, later stray mem_opdone ignored, new job correct.

Source files
------------

// File: rtl/matrix_engine.sv
`timescale 1ns/1ps
// Memory-mapped matrix coprocessor: MUL / ADD / TRANSPOSE / MAC over a shared single-port memory.
// Latency: 4 header reads + 1 check cycle, then per element its reads/MAC cycles/write, each memory op + 1 idle cycle.
// Backpressure: every transaction is held until mem_opdone; mem_operation drops to 00 for one cycle between ops.
module matrix_engine #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int ACC_W    = 64,
   parameter int SATURATE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [1:0]        op_mode,
   input  logic [ADDR_W-1:0] base_i,
   input  logic              mem_opdone,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [1:0]        mem_operation,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_CHECK, S_RD_C, S_RD_A, S_RD_B, S_MACC, S_WR, S_DONE, S_ERR
   } state_t;

   localparam logic [1:0] M_MUL = 2'b00;
   localparam logic [1:0] M_ADD = 2'b01;
   localparam logic [1:0] M_TRN = 2'b10;
   localparam logic [1:0] M_MAC = 2'b11;

   state_t              r_state;
   state_t              w_next;
   logic [1:0]          r_mode;
   logic [ADDR_W-1:0]   r_base;
   logic [1:0]          r_hcnt;
   logic [ADDR_W-1:0]   r_wa, r_ha, r_wb, r_hb;
   logic [ADDR_W-1:0]   r_a_base, r_b_base, r_c_base;
   logic [ADDR_W-1:0]   r_i, r_j, r_k;
   logic [DATA_W-1:0]   r_a, r_b;
   logic [ACC_W-1:0]    r_acc;
   logic                r_gap;
   logic                r_en_prev;

   logic                w_mem_state;
   logic                w_ack;
   logic                w_is_mul;
   logic                w_dim_err;
   logic [ADDR_W-1:0]   w_ncol;
   logic                w_last_i, w_last_j, w_last_k;
   logic [ADDR_W-1:0]   w_a_base, w_b_base, w_c_base;
   logic [ADDR_W-1:0]   w_a_addr, w_b_addr, w_c_addr;
   logic [2*DATA_W-1:0] w_prod;
   logic                w_over;
   logic [DATA_W-1:0]   w_wdata;

   // A memory op is live only in a memory state outside the enforced idle cycle after an ack.
   assign w_mem_state = (r_state == S_HDR) || (r_state == S_RD_C) || (r_state == S_RD_A) ||
                        (r_state == S_RD_B) || (r_state == S_WR);
   assign w_ack       = mem_opdone && w_mem_state && !r_gap;

   assign w_is_mul  = (r_mode == M_MUL) || (r_mode == M_MAC);
   assign w_dim_err = (r_wa == '0) || (r_ha == '0) ||
                      ((r_mode != M_TRN) && ((r_wb == '0) || (r_hb == '0))) ||
                      (w_is_mul && (r_wa != r_hb)) ||
                      ((r_mode == M_ADD) && ((r_wa != r_wb) || (r_ha != r_hb)));

   // C has wb columns for the product modes, wa columns otherwise (i,j walk the source A).
   assign w_ncol   = w_is_mul ? r_wb : r_wa;
   assign w_last_i = (r_i == r_ha - 1'b1);
   assign w_last_j = (r_j == w_ncol - 1'b1);
   assign w_last_k = (r_k == r_wa - 1'b1);

   // Operand region bases, only meaningful once the header is loaded (used in CHECK).
   assign w_a_base = r_base + ADDR_W'(4);
   assign w_b_base = w_a_base + r_ha * r_wa;
   assign w_c_base = (r_mode == M_TRN) ? w_b_base : (w_b_base + r_hb * r_wb);

   assign w_a_addr = r_a_base + r_i * r_wa + (w_is_mul ? r_k : r_j);
   assign w_b_addr = w_is_mul ? (r_b_base + r_k * r_wb + r_j) : (r_b_base + r_i * r_wa + r_j);
   assign w_c_addr = (r_mode == M_TRN) ? (r_c_base + r_j * r_ha + r_i)
                                       : (r_c_base + r_i * w_ncol + r_j);

   assign w_prod  = (2*DATA_W)'(r_a) * (2*DATA_W)'(r_b);
   assign w_over  = |r_acc[ACC_W-1:DATA_W];
   assign w_wdata = ((SATURATE != 0) && w_over) ? '1 : r_acc[DATA_W-1:0];

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic: header fetch, dimension check, then the i/j/k element loop.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (enable && !r_en_prev) w_next = S_HDR;
         S_HDR:   if (w_ack && (r_hcnt == 2'd3)) w_next = S_CHECK;
         S_CHECK: begin
            if (w_dim_err)             w_next = S_ERR;
            else if (r_mode == M_MAC)  w_next = S_RD_C;
            else                       w_next = S_RD_A;
         end
         S_RD_C:  if (w_ack) w_next = S_RD_A;
         S_RD_A:  if (w_ack) w_next = (r_mode == M_TRN) ? S_WR : S_RD_B;
         S_RD_B:  if (w_ack) w_next = (r_mode == M_ADD) ? S_WR : S_MACC;
         S_MACC:  w_next = w_last_k ? S_WR : S_RD_A;
         S_WR: begin
            if (w_ack) begin
               if (w_last_i && w_last_j)  w_next = S_DONE;
               else if (r_mode == M_MAC)  w_next = S_RD_C;
               else                       w_next = S_RD_A;
            end
         end
         S_DONE:  if (!enable) w_next = S_IDLE;
         S_ERR:   if (!enable) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output decode: status flags and the memory request for the current state.
   always_comb begin
      busy          = 1'b0;
      done          = 1'b0;
      error         = 1'b0;
      mem_operation = 2'b00;
      addr_o        = '0;
      data_o        = '0;
      case (r_state)
         S_HDR:   begin busy = 1'b1; addr_o = r_base + ADDR_W'(r_hcnt); end
         S_CHECK: busy = 1'b1;
         S_RD_C:  begin busy = 1'b1; addr_o = w_c_addr; end
         S_RD_A:  begin busy = 1'b1; addr_o = w_a_addr; end
         S_RD_B:  begin busy = 1'b1; addr_o = w_b_addr; end
         S_MACC:  busy = 1'b1;
         S_WR:    begin busy = 1'b1; addr_o = w_c_addr; data_o = w_wdata; end
         S_DONE:  done = 1'b1;
         S_ERR:   error = 1'b1;
         default: ;
      endcase
      if (w_mem_state && !r_gap)
         mem_operation = (r_state == S_WR) ? 2'b11 : 2'b01;
   end

   // Datapath: job latch, header capture, loop indices and the accumulator.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode    <= '0;
         r_base    <= '0;
         r_hcnt    <= '0;
         r_wa      <= '0;
         r_ha      <= '0;
         r_wb      <= '0;
         r_hb      <= '0;
         r_a_base  <= '0;
         r_b_base  <= '0;
         r_c_base  <= '0;
         r_i       <= '0;
         r_j       <= '0;
         r_k       <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_gap     <= 1'b0;
         r_en_prev <= 1'b0;
      end else begin
         r_en_prev <= enable;
         r_gap     <= w_ack;
         case (r_state)
            S_IDLE: begin
               if (enable && !r_en_prev) begin
                  r_mode <= op_mode;
                  r_base <= base_i;
                  r_hcnt <= '0;
                  r_i    <= '0;
                  r_j    <= '0;
                  r_k    <= '0;
                  r_acc  <= '0;
               end
            end
            S_HDR: begin
               if (w_ack) begin
                  case (r_hcnt)
                     2'd0:    r_wa <= ADDR_W'(data_i);
                     2'd1:    r_ha <= ADDR_W'(data_i);
                     2'd2:    r_wb <= ADDR_W'(data_i);
                     default: r_hb <= ADDR_W'(data_i);
                  endcase
                  r_hcnt <= r_hcnt + 2'd1;
               end
            end
            S_CHECK: begin
               r_a_base <= w_a_base;
               r_b_base <= w_b_base;
               r_c_base <= w_c_base;
               r_acc    <= '0;
            end
            S_RD_C: if (w_ack) r_acc <= ACC_W'(data_i);
            S_RD_A: begin
               if (w_ack) begin
                  r_a <= data_i;
                  if (r_mode == M_TRN) r_acc <= ACC_W'(data_i);
               end
            end
            S_RD_B: begin
               if (w_ack) begin
                  if (r_mode == M_ADD) r_acc <= ACC_W'(r_a) + ACC_W'(data_i);
                  else                 r_b   <= data_i;
               end
            end
            S_MACC: begin
               r_acc <= r_acc + ACC_W'(w_prod);
               r_k   <= w_last_k ? '0 : (r_k + 1'b1);
            end
            S_WR: begin
               if (w_ack) begin
                  r_k   <= '0;
                  r_acc <= '0;
                  if (w_last_j) begin
                     r_j <= '0;
                     r_i <= r_i + 1'b1;
                  end else begin
                     r_j <= r_j + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_engine.sv
`timescale 1ns/1ps
// Bench for matrix_engine: randomized jobs checked against an arithmetic reference model,
// plus directed MUL/ADD/TRANSPOSE/MAC/error/saturation/mid-job reset scenarios.
module tb_matrix_engine;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, enable;
   logic [1:0]  op_mode;
   logic [31:0] base_i;
   logic        mem_opdone;
   logic [31:0] data_i, data_o, addr_o;
   logic [1:0]  mem_operation;
   logic        busy, done, error;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem [0:1023];
   int          n_rd = 0, n_wr = 0, proto_err = 0;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          dly_lo = 0, dly_hi = 7;
   bit          resp_hold = 1'b0;
   int          stray_req = 0, stray_done = 0;

   matrix_engine #(.DATA_W(32), .ADDR_W(32), .ACC_W(64), .SATURATE(1)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .op_mode(op_mode), .base_i(base_i),
      .mem_opdone(mem_opdone), .data_i(data_i), .data_o(data_o), .addr_o(addr_o),
      .mem_operation(mem_operation), .busy(busy), .done(done), .error(error));

   // Two narrow instances to exercise saturating and wrapping writeback.
   logic       en8;
   logic [1:0] op8 = 2'b00;
   logic [7:0] base8 = 8'h00;
   logic       s_opdone [2];
   logic [7:0] s_din [2];
   logic [7:0] s_dout [2];
   logic [7:0] s_addr [2];
   logic [1:0] s_op [2];
   logic       s_busy [2];
   logic       s_done [2];
   logic       s_err [2];
   logic [7:0] mem8 [0:15];
   logic [7:0] w8 [2];
   int         w8_cnt [2];

   matrix_engine #(.DATA_W(8), .ADDR_W(8), .ACC_W(16), .SATURATE(1)) u_sat (
      .clk(clk), .reset(reset), .enable(en8), .op_mode(op8), .base_i(base8),
      .mem_opdone(s_opdone[0]), .data_i(s_din[0]), .data_o(s_dout[0]), .addr_o(s_addr[0]),
      .mem_operation(s_op[0]), .busy(s_busy[0]), .done(s_done[0]), .error(s_err[0]));

   matrix_engine #(.DATA_W(8), .ADDR_W(8), .ACC_W(16), .SATURATE(0)) u_wrap (
      .clk(clk), .reset(reset), .enable(en8), .op_mode(op8), .base_i(base8),
      .mem_opdone(s_opdone[1]), .data_i(s_din[1]), .data_o(s_dout[1]), .addr_o(s_addr[1]),
      .mem_operation(s_op[1]), .busy(s_busy[1]), .done(s_done[1]), .error(s_err[1]));

   // Memory responder for the main instance: random ack delay, protocol watch, write log.
   initial begin : responder
      bit          pending;
      int          cnt;
      logic [31:0] p_addr, p_data;
      logic [1:0]  p_op;
      pending = 1'b0; cnt = 0; p_addr = '0; p_data = '0; p_op = '0;
      mem_opdone = 1'b0;
      data_i = '0;
      forever begin
         @(negedge clk);
         if (resp_hold || reset) begin
            pending = 1'b0;
            mem_opdone = (stray_done != stray_req);
            if (mem_opdone) begin
               stray_done++;
               data_i = $urandom;
            end
         end else if (mem_opdone) begin
            mem_opdone = 1'b0;
            if (mem_operation != 2'b00) proto_err++;
         end else if (mem_operation == 2'b01 || mem_operation == 2'b11) begin
            if (!pending) begin
               pending = 1'b1;
               cnt = $urandom_range(dly_hi, dly_lo);
               p_addr = addr_o; p_op = mem_operation; p_data = data_o;
            end else if (addr_o !== p_addr || mem_operation !== p_op ||
                         (p_op == 2'b11 && data_o !== p_data)) begin
               proto_err++;
            end
            if (addr_o[31:10] != '0) proto_err++;
            if (cnt == 0) begin
               if (mem_operation == 2'b01) begin
                  data_i = mem[addr_o[9:0]];
                  n_rd++;
               end else begin
                  wr_addr_q.push_back(addr_o);
                  wr_data_q.push_back(data_o);
                  n_wr++;
               end
               mem_opdone = 1'b1;
               pending = 1'b0;
            end else begin
               cnt--;
            end
         end else if (mem_operation != 2'b00) begin
            proto_err++;
         end
      end
   end

   // Zero-delay responder for the two narrow instances.
   initial begin : resp8
      for (int s = 0; s < 2; s++) begin
         s_opdone[s] = 1'b0; s_din[s] = '0; w8[s] = '0; w8_cnt[s] = 0;
      end
      forever begin
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            if (s_opdone[s]) begin
               s_opdone[s] = 1'b0;
            end else if (s_op[s] == 2'b01) begin
               s_din[s] = mem8[s_addr[s][3:0]];
               s_opdone[s] = 1'b1;
            end else if (s_op[s] == 2'b11) begin
               w8[s] = s_dout[s];
               w8_cnt[s]++;
               s_opdone[s] = 1'b1;
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic load_hdr(input int base, input int wa, input int ha, input int wb, input int hb);
      mem[base]   = wa;
      mem[base+1] = ha;
      mem[base+2] = wb;
      mem[base+3] = hb;
   endtask

   // Run one job; expected writes, read count and error flag come from the model below.
   task automatic run_job(input logic [1:0] mode, input int base, input string name, output int wbase);
      int          wa, ha, wb, hb, a0, b0, c0, exp_rd, rd0, pe0, cyc;
      bit          exp_err;
      logic [63:0] acc;
      int          ea[$];
      logic [31:0] ed[$];
      wa = int'(mem[base]); ha = int'(mem[base+1]); wb = int'(mem[base+2]); hb = int'(mem[base+3]);
      a0 = base + 4;
      b0 = a0 + ha * wa;
      c0 = (mode == 2'b10) ? b0 : b0 + hb * wb;
      exp_err = (wa == 0) || (ha == 0) || (mode != 2'b10 && (wb == 0 || hb == 0)) ||
                ((mode == 2'b00 || mode == 2'b11) && wa != hb) ||
                (mode == 2'b01 && (wa != wb || ha != hb));
      exp_rd = 4;
      if (!exp_err) begin
         if (mode == 2'b00 || mode == 2'b11) begin
            for (int i = 0; i < ha; i++)
               for (int j = 0; j < wb; j++) begin
                  acc = (mode == 2'b11) ? 64'(mem[c0 + i*wb + j]) : 64'd0;
                  if (mode == 2'b11) exp_rd++;
                  for (int k = 0; k < wa; k++) begin
                     acc = acc + 64'(mem[a0 + i*wa + k]) * 64'(mem[b0 + k*wb + j]);
                     exp_rd += 2;
                  end
                  ea.push_back(c0 + i*wb + j);
                  ed.push_back(acc > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : acc[31:0]);
               end
         end else if (mode == 2'b01) begin
            for (int i = 0; i < ha; i++)
               for (int j = 0; j < wa; j++) begin
                  acc = 64'(mem[a0 + i*wa + j]) + 64'(mem[b0 + i*wa + j]);
                  exp_rd += 2;
                  ea.push_back(c0 + i*wa + j);
                  ed.push_back(acc > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : acc[31:0]);
               end
         end else begin
            for (int i = 0; i < ha; i++)
               for (int j = 0; j < wa; j++) begin
                  exp_rd++;
                  ea.push_back(c0 + j*ha + i);
                  ed.push_back(mem[a0 + i*wa + j]);
               end
         end
      end
      rd0 = n_rd; wbase = n_wr; pe0 = proto_err;
      op_mode = mode; base_i = base; enable = 1'b1;
      tick(1);
      op_mode = 2'($urandom); base_i = $urandom;
      cyc = 0;
      while (!(done || error) && cyc < 5000) begin tick(1); cyc++; end
      checks++;
      if (!(done || error)) begin failures++; $display("FAIL %s timeout: no done/error after %0d cycles", name, cyc); end
      tick(3);
      checks++;
      if (error !== exp_err || done !== !exp_err) begin
         failures++; $display("FAIL %s flags: done=%b error=%b expected error=%b", name, done, error, exp_err);
      end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL %s busy after finish: got %b expected 0", name, busy); end
      checks++;
      if (n_rd - rd0 != exp_rd) begin failures++; $display("FAIL %s reads: got %0d expected %0d", name, n_rd - rd0, exp_rd); end
      checks++;
      if (n_wr - wbase != ea.size()) begin failures++; $display("FAIL %s writes: got %0d expected %0d", name, n_wr - wbase, ea.size()); end
      for (int k = 0; k < ea.size(); k++) begin
         if (wbase + k < wr_addr_q.size()) begin
            checks++;
            if (wr_addr_q[wbase+k] !== 32'(ea[k]) || wr_data_q[wbase+k] !== ed[k]) begin
               failures++;
               $display("FAIL %s write %0d: got addr=%h data=%h expected addr=%h data=%h",
                        name, k, wr_addr_q[wbase+k], wr_data_q[wbase+k], 32'(ea[k]), ed[k]);
            end
         end
      end
      checks++;
      if (proto_err != pe0) begin failures++; $display("FAIL %s handshake violations: got %0d expected 0", name, proto_err - pe0); end
      enable = 1'b0;
      tick(2);
      checks++;
      if (done !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL %s rearm: done=%b error=%b busy=%b expected all 0", name, done, error, busy);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick(2);
      checks++;
      if ({busy, done, error, mem_operation} !== 5'b0 || addr_o !== '0 || data_o !== '0) begin
         failures++; $display("FAIL reset outputs: busy=%b done=%b error=%b op=%b addr=%h data=%h expected all 0",
                              busy, done, error, mem_operation, addr_o, data_o);
      end
      reset = 1'b0;
      tick(1);
   endtask

   task automatic test_mul_directed;
      int w0;
      logic [31:0] exp [4];
      exp[0] = 19; exp[1] = 22; exp[2] = 43; exp[3] = 50;
      load_hdr(256, 2, 2, 2, 2);
      for (int x = 0; x < 8; x++) mem[260 + x] = x + 1;
      run_job(2'b00, 256, "mul2x2", w0);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (w0 + k >= wr_data_q.size() || wr_addr_q[w0+k] !== 32'h10C + k || wr_data_q[w0+k] !== exp[k]) begin
            failures++; $display("FAIL mul2x2 C[%0d]: expected %0d at %h", k, exp[k], 32'h10C + k);
         end
      end
   endtask

   task automatic test_add_directed;
      int w0;
      load_hdr(256, 2, 2, 2, 2);
      for (int x = 0; x < 8; x++) mem[260 + x] = x + 1;
      run_job(2'b01, 256, "add2x2", w0);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (w0 + k >= wr_data_q.size() || wr_addr_q[w0+k] !== 32'h10C + k || wr_data_q[w0+k] !== 32'(6 + 2*k)) begin
            failures++; $display("FAIL add2x2 C[%0d]: expected %0d at %h", k, 6 + 2*k, 32'h10C + k);
         end
      end
   endtask

   task automatic test_transpose;
      int w0;
      logic [31:0] img [6];
      logic [31:0] exp [6];
      exp[0] = 1; exp[1] = 4; exp[2] = 2; exp[3] = 5; exp[4] = 3; exp[5] = 6;
      for (int k = 0; k < 6; k++) img[k] = 32'hDEAD_BEEF;
      load_hdr(256, 3, 2, 0, 0);
      for (int x = 0; x < 6; x++) mem[260 + x] = x + 1;
      run_job(2'b10, 256, "transpose", w0);
      for (int k = w0; k < wr_addr_q.size(); k++)
         if (wr_addr_q[k] >= 32'h10A && wr_addr_q[k] < 32'h110) img[wr_addr_q[k] - 32'h10A] = wr_data_q[k];
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (img[k] !== exp[k]) begin
            failures++; $display("FAIL transpose C[%0d]: got %0d expected %0d", k, img[k], exp[k]);
         end
      end
   endtask

   task automatic test_dim_error;
      int w0;
      load_hdr(256, 3, 2, 2, 2);
      run_job(2'b00, 256, "dim_error", w0);
   endtask

   task automatic test_mac;
      int w0;
      load_hdr(256, 1, 1, 1, 1);
      mem[260] = 3; mem[261] = 4; mem[262] = 100;
      run_job(2'b11, 256, "mac1x1", w0);
      checks++;
      if (w0 >= wr_data_q.size() || wr_data_q[w0] !== 32'd112 || wr_addr_q[w0] !== 32'h106) begin
         failures++; $display("FAIL mac1x1 result: expected 112 at 106");
      end
   endtask

   task automatic test_random;
      int w0, base, wa, ha, wb, hb;
      logic [1:0] mode;
      for (int t = 0; t < 14; t++) begin
         mode = 2'($urandom_range(3, 0));
         base = $urandom_range(600, 0);
         wa = $urandom_range(3, 1); ha = $urandom_range(3, 1);
         wb = $urandom_range(3, 1); hb = $urandom_range(3, 1);
         if (t % 4 != 3) begin
            if (mode == 2'b01) begin wb = wa; hb = ha; end
            else hb = wa;
         end
         if (t % 5 == 4) ha = 0;
         for (int x = 0; x < 40; x++) mem[base + 4 + x] = (t % 2 == 1) ? $urandom : $urandom_range(20, 0);
         load_hdr(base, wa, ha, wb, hb);
         run_job(mode, base, $sformatf("random%0d", t), w0);
      end
   endtask

   task automatic test_reset_mid_job;
      int w0, cyc;
      load_hdr(64, 2, 2, 2, 2);
      for (int x = 0; x < 8; x++) mem[68 + x] = x + 9;
      dly_lo = 4; dly_hi = 6;
      op_mode = 2'b00; base_i = 64; enable = 1'b1;
      cyc = 0;
      while (!(mem_operation == 2'b01 && addr_o == 32'd72) && cyc < 2000) begin tick(1); cyc++; end
      checks++;
      if (cyc >= 2000) begin failures++; $display("FAIL reset_mid: first B read never seen within %0d cycles", cyc); end
      resp_hold = 1'b1;
      reset = 1'b1;
      tick(1);
      checks++;
      if ({busy, done, error, mem_operation} !== 5'b0 || addr_o !== '0 || data_o !== '0) begin
         failures++; $display("FAIL reset_mid outputs: busy=%b op=%b addr=%h expected all 0", busy, mem_operation, addr_o);
      end
      reset = 1'b0; enable = 1'b0;
      tick(1);
      stray_req++;
      tick(3);
      checks++;
      if ({busy, done, error, mem_operation} !== 5'b0) begin
         failures++; $display("FAIL stray opdone: busy=%b done=%b error=%b op=%b expected all 0", busy, done, error, mem_operation);
      end
      resp_hold = 1'b0; dly_lo = 0; dly_hi = 7;
      tick(1);
      run_job(2'b00, 64, "after_reset", w0);
   endtask

   task automatic test_saturate8;
      int cyc;
      for (int x = 0; x < 16; x++) mem8[x] = '0;
      mem8[0] = 1; mem8[1] = 1; mem8[2] = 1; mem8[3] = 1; mem8[4] = 16; mem8[5] = 16;
      en8 = 1'b1;
      cyc = 0;
      while (!(s_done[0] && s_done[1]) && cyc < 500) begin tick(1); cyc++; end
      checks++;
      if (!(s_done[0] && s_done[1])) begin failures++; $display("FAIL sat8 timeout: done=%b/%b", s_done[0], s_done[1]); end
      checks++;
      if (w8[0] !== 8'd255 || w8_cnt[0] != 1) begin failures++; $display("FAIL sat8 clamp: got %0d (%0d writes) expected 255 (1 write)", w8[0], w8_cnt[0]); end
      checks++;
      if (w8[1] !== 8'd0 || w8_cnt[1] != 1) begin failures++; $display("FAIL sat8 wrap: got %0d (%0d writes) expected 0 (1 write)", w8[1], w8_cnt[1]); end
      en8 = 1'b0;
      tick(2);
      checks++;
      if (s_done[0] !== 1'b0 || s_done[1] !== 1'b0) begin failures++; $display("FAIL sat8 rearm: done=%b/%b expected 0", s_done[0], s_done[1]); end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; en8 = 1'b0; op_mode = '0; base_i = '0;
      for (int x = 0; x < 1024; x++) mem[x] = $urandom;
      for (int x = 0; x < 16; x++) mem8[x] = '0;
      test_reset();
      test_mul_directed();
      test_add_directed();
      test_transpose();
      test_dim_error();
      test_mac();
      test_random();
      test_reset_mid_job();
      test_saturate8();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
